// File: rtl/resource_arbiter_if.sv
// resource_arbiter_if: bundles the requester-facing and resource-facing signals of
// resource_arbiter.
//   Requester side : req_valid/req_address/req_id in, req_ready out (one-hot accept),
//                    rsp_valid (one-hot pulse), rsp_data, rsp_id, rsp_error out.
//   Resource side  : res_in_address/res_in_id/res_in_valid out,
//                    res_out_data/res_out_id/res_out_valid/res_out_ready in.
//   Status         : busy, grant_idx out.
// Modports: slave = arbiter view, master = environment (requesters + resource) view.
interface resource_arbiter_if #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned DATA_WIDTH    = 16
);
  localparam int unsigned GRANT_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Requester side, flattened: slice i belongs to requester i
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_REQ*ID_WIDTH-1:0]      req_id;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [DATA_WIDTH-1:0]            rsp_data;
  logic [ID_WIDTH-1:0]              rsp_id;
  logic                             rsp_error;

  // Resource side
  logic [ADDRESS_WIDTH-1:0]         res_in_address;
  logic [ID_WIDTH-1:0]              res_in_id;
  logic                             res_in_valid;
  logic [DATA_WIDTH-1:0]            res_out_data;
  logic [ID_WIDTH-1:0]              res_out_id;
  logic                             res_out_valid;
  logic                             res_out_ready;

  // Status
  logic                             busy;
  logic [GRANT_WIDTH-1:0]           grant_idx;

  modport slave (
    input  req_valid, req_address, req_id,
    input  res_out_data, res_out_id, res_out_valid, res_out_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_error,
    output res_in_address, res_in_id, res_in_valid,
    output busy, grant_idx
  );

  modport master (
    output req_valid, req_address, req_id,
    output res_out_data, res_out_id, res_out_valid, res_out_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_error,
    input  res_in_address, res_in_id, res_in_valid,
    input  busy, grant_idx
  );
endinterface

// File: rtl/resource_arbiter.sv
// resource_arbiter: shares one resource among NUM_REQ requesters with round-robin
// arbitration and a single transaction in flight.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (also resets the resource)
//   bus     : resource_arbiter_if.slave (requester handshake, resource handshake, status)
// The issued request carries the requester index as its ID; the matching response is
// steered back to that requester with the requester's own tag restored. A watchdog
// produces an error response if the resource stays silent for TIMEOUT WAIT cycles.
module resource_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned TIMEOUT_WIDTH = 7,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned DATA_WIDTH    = 16
) (
  input logic               clk,
  input logic               reset_n,
  resource_arbiter_if.slave bus
);

  localparam int unsigned GRANT_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StRespond
  } state_e;

  state_e                   state_q, state_d;
  logic [GRANT_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GRANT_WIDTH-1:0]   grant_q, grant_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic [ID_WIDTH-1:0]      tag_q, tag_d;

  // Registered outputs
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [ID_WIDTH-1:0]      rsp_id_q, rsp_id_d;
  logic                     rsp_error_q, rsp_error_d;
  logic                     res_in_valid_q, res_in_valid_d;
  logic [ADDRESS_WIDTH-1:0] res_in_address_q, res_in_address_d;
  logic [ID_WIDTH-1:0]      res_in_id_q, res_in_id_d;
  logic                     busy_q, busy_d;

  // Round-robin winner
  logic [NUM_REQ-1:0]       winner;
  logic [GRANT_WIDTH-1:0]   win_idx;
  logic                     win_found;
  logic [GRANT_WIDTH-1:0]   win_next_ptr;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     transfer;
  logic                     rsp_match;
  logic                     wd_expired;

  // First valid request scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    winner    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(rr_ptr_q) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!win_found && bus.req_valid[GRANT_WIDTH'(idx)]) begin
        win_found = 1'b1;
        win_idx   = GRANT_WIDTH'(idx);
      end
    end
    winner[win_idx] = win_found;
  end

  assign win_next_ptr = (win_idx == GRANT_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Only combinational output; gated by reset_n so it reads 0 while reset is held.
  assign req_ready = (reset_n && state_q == StIdle && bus.res_out_ready) ? winner : '0;
  assign transfer  = |(bus.req_valid & req_ready);

  // Responses with another requester's index are stale or foreign; ignore them.
  assign rsp_match  = bus.res_out_valid && (bus.res_out_id == ID_WIDTH'(grant_q));
  assign wd_expired = (wd_q == TIMEOUT_WIDTH'(TIMEOUT - 1));

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    grant_d          = grant_q;
    wd_d             = wd_q;
    tag_d            = tag_q;
    rsp_valid_d      = '0;
    rsp_data_d       = rsp_data_q;
    rsp_id_d         = rsp_id_q;
    rsp_error_d      = rsp_error_q;
    res_in_valid_d   = 1'b0;
    res_in_address_d = res_in_address_q;
    res_in_id_d      = res_in_id_q;

    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          state_d          = StIssue;
          grant_d          = win_idx;
          rr_ptr_d         = win_next_ptr;
          tag_d            = bus.req_id[32'(win_idx)*ID_WIDTH +: ID_WIDTH];
          // Issue outputs are registered here so they appear in the ISSUE cycle.
          res_in_valid_d   = 1'b1;
          res_in_address_d = bus.req_address[32'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          res_in_id_d      = ID_WIDTH'(win_idx);
        end
      end
      StIssue: begin
        state_d = StWait;
        wd_d    = '0;
      end
      StWait: begin
        wd_d = wd_q + 1'b1;
        // A match wins over a simultaneous watchdog expiry.
        if (rsp_match) begin
          state_d              = StRespond;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_data_d           = bus.res_out_data;
          rsp_id_d             = tag_q;
          rsp_error_d          = 1'b0;
        end else if (wd_expired) begin
          state_d              = StRespond;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_data_d           = '0;
          rsp_id_d             = tag_q;
          rsp_error_d          = 1'b1;
        end
      end
      StRespond: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      rr_ptr_q         <= '0;
      grant_q          <= '0;
      wd_q             <= '0;
      tag_q            <= '0;
      rsp_valid_q      <= '0;
      rsp_data_q       <= '0;
      rsp_id_q         <= '0;
      rsp_error_q      <= 1'b0;
      res_in_valid_q   <= 1'b0;
      res_in_address_q <= '0;
      res_in_id_q      <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      grant_q          <= grant_d;
      wd_q             <= wd_d;
      tag_q            <= tag_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      rsp_id_q         <= rsp_id_d;
      rsp_error_q      <= rsp_error_d;
      res_in_valid_q   <= res_in_valid_d;
      res_in_address_q <= res_in_address_d;
      res_in_id_q      <= res_in_id_d;
      busy_q           <= busy_d;
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_id         = rsp_id_q;
  assign bus.rsp_error      = rsp_error_q;
  assign bus.res_in_valid   = res_in_valid_q;
  assign bus.res_in_address = res_in_address_q;
  assign bus.res_in_id      = res_in_id_q;
  assign bus.busy           = busy_q;
  assign bus.grant_idx      = grant_q;

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(rsp_valid_q));
  a_issue_busy: assert property (@(posedge clk) disable iff (!reset_n)
    res_in_valid_q |-> busy_q);

endmodule

// File: tb/tb_resource_arbiter.sv
// tb_resource_arbiter: directed, table-driven bench for resource_arbiter with a small
// resource model (response = address + 0x200, configurable delay, stall, injection).
module tb_resource_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  resource_arbiter_if #(
    .NUM_REQ(NR), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)
  ) bus ();

  resource_arbiter #(
    .NUM_REQ(NR), .TIMEOUT(TO), .TIMEOUT_WIDTH(3),
    .ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester tables
  logic [AW-1:0] addr_tab [NR] = '{8'h03, 8'h14, 8'h05, 8'h36};
  logic [IW-1:0] tag_tab  [NR] = '{4'hA, 4'h7, 4'h3, 4'hC};

  // Resource model
  int            res_delay;
  bit            stall;
  logic          inj_valid;
  logic [IW-1:0] inj_id;
  logic [DW-1:0] inj_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_id;
  logic          pend;
  int            cnt;
  logic [AW-1:0] p_addr;
  logic [IW-1:0] p_id;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_id    <= '0;
      pend    <= 1'b0;
      cnt     <= 0;
      p_addr  <= '0;
      p_id    <= '0;
    end else begin
      m_valid <= 1'b0;
      if (bus.res_in_valid && !stall) begin
        if (res_delay == 0) begin
          m_valid <= 1'b1;
          m_data  <= DW'(bus.res_in_address) + 16'h0200;
          m_id    <= bus.res_in_id;
        end else begin
          pend   <= 1'b1;
          cnt    <= res_delay - 1;
          p_addr <= bus.res_in_address;
          p_id   <= bus.res_in_id;
        end
      end else if (pend) begin
        if (cnt == 0) begin
          pend    <= 1'b0;
          m_valid <= 1'b1;
          m_data  <= DW'(p_addr) + 16'h0200;
          m_id    <= p_id;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  assign bus.res_out_valid = m_valid | inj_valid;
  assign bus.res_out_id    = inj_valid ? inj_id : m_id;
  assign bus.res_out_data  = inj_valid ? inj_data : m_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    check({p, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({p, "_rsp_data"}, 32'(bus.rsp_data), 32'h0);
    check({p, "_rsp_id"}, 32'(bus.rsp_id), 32'h0);
    check({p, "_rsp_error"}, 32'(bus.rsp_error), 32'h0);
    check({p, "_res_in_valid"}, 32'(bus.res_in_valid), 32'h0);
    check({p, "_res_in_address"}, 32'(bus.res_in_address), 32'h0);
    check({p, "_res_in_id"}, 32'(bus.res_in_id), 32'h0);
    check({p, "_busy"}, 32'(bus.busy), 32'h0);
    check({p, "_grant_idx"}, 32'(bus.grant_idx), 32'h0);
  endtask

  // Present mask, wait (bounded) for the accept, check the accept and the ISSUE cycle.
  task automatic accept_req(input string p, input logic [NR-1:0] mask, input int g,
                            output int c0);
    int n;
    n = 0;
    bus.req_valid = mask;
    #1;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({p, "_req_ready"}, 32'(bus.req_ready), 32'(1 << g));
    check({p, "_busy_idle"}, 32'(bus.busy), 32'h0);
    c0 = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    @(negedge clk);
    check({p, "_res_in_valid"}, 32'(bus.res_in_valid), 32'h1);
    check({p, "_res_in_id"}, 32'(bus.res_in_id), 32'(g));
    check({p, "_res_in_address"}, 32'(bus.res_in_address), 32'(addr_tab[g]));
    check({p, "_busy_issue"}, 32'(bus.busy), 32'h1);
    check({p, "_grant_idx"}, 32'(bus.grant_idx), 32'(g));
  endtask

  task automatic expect_rsp(input string p, input int g, input bit err, input int lat,
                            input int c0);
    int n;
    logic [31:0] exp_data;
    n = 0;
    exp_data = err ? 32'h0 : 32'(addr_tab[g]) + 32'h200;
    @(negedge clk);
    check({p, "_res_in_valid_drop"}, 32'(bus.res_in_valid), 32'h0);
    while (bus.rsp_valid == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({p, "_rsp_latency"}, 32'(cyc - c0), 32'(lat));
    check({p, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << g));
    check({p, "_rsp_data"}, 32'(bus.rsp_data), exp_data);
    check({p, "_rsp_id"}, 32'(bus.rsp_id), 32'(tag_tab[g]));
    check({p, "_rsp_error"}, 32'(bus.rsp_error), 32'(err));
    @(negedge clk);
    check({p, "_rsp_pulse_end"}, 32'(bus.rsp_valid), 32'h0);
    check({p, "_busy_end"}, 32'(bus.busy), 32'h0);
  endtask

  typedef struct {
    logic [NR-1:0] mask;
    int            delay;  // -1: resource stalls
    int            g;
    bit            err;
    int            lat;    // accept cycle to rsp_valid cycle
  } vec_t;

  vec_t vecs [12];
  int   c0;
  int   prev_c0;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset_n           = 1'b0;
    bus.req_valid     = '0;
    bus.req_address   = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    bus.req_id        = {tag_tab[3], tag_tab[2], tag_tab[1], tag_tab[0]};
    bus.res_out_ready = 1'b1;
    inj_valid         = 1'b0;
    inj_id            = '0;
    inj_data          = '0;
    res_delay         = 2;
    stall             = 1'b0;
    c0                = 0;
    prev_c0           = 0;

    vecs[0]  = '{4'b0100,  2, 2, 1'b0, 5};  // single request, D=2
    vecs[1]  = '{4'b1111,  2, 3, 1'b0, 5};
    vecs[2]  = '{4'b1111,  2, 0, 1'b0, 5};  // round robin 0,1,2,3,0
    vecs[3]  = '{4'b1111,  2, 1, 1'b0, 5};
    vecs[4]  = '{4'b1111,  2, 2, 1'b0, 5};
    vecs[5]  = '{4'b1111,  2, 3, 1'b0, 5};
    vecs[6]  = '{4'b1111,  2, 0, 1'b0, 5};
    vecs[7]  = '{4'b1001,  2, 3, 1'b0, 5};  // rr_ptr=1: 3 before 0
    vecs[8]  = '{4'b1001,  2, 0, 1'b0, 5};
    vecs[9]  = '{4'b0010, -1, 1, 1'b1, 6};  // timeout: TIMEOUT+2
    vecs[10] = '{4'b0001,  3, 0, 1'b0, 6};  // match on the expiry cycle wins
    vecs[11] = '{4'b0100,  1, 2, 1'b0, 4};

    // Reset state, with a request pending while reset is held
    repeat (2) @(negedge clk);
    bus.req_valid = 4'b0100;
    #1;
    check_reset("por");
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      res_delay = (vecs[i].delay < 0) ? 0 : vecs[i].delay;
      stall     = (vecs[i].delay < 0);
      accept_req($sformatf("v%0d", i), vecs[i].mask, vecs[i].g, c0);
      if (i > 0) begin
        check($sformatf("v%0d_spacing", i), 32'(c0 - prev_c0), 32'(vecs[i-1].lat + 1));
      end
      expect_rsp($sformatf("v%0d", i), vecs[i].g, vecs[i].err, vecs[i].lat, c0);
      prev_c0 = c0;
    end

    // Timeout, then a stale response in IDLE carrying the last grant's index
    stall = 1'b1;
    accept_req("stale", 4'b1000, 3, c0);
    expect_rsp("stale", 3, 1'b1, TO + 2, c0);
    @(posedge clk);
    #1;
    inj_valid = 1'b1;
    inj_id    = 4'd3;
    inj_data  = 16'h1234;
    @(posedge clk);
    #1;
    inj_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stale_no_rsp%0d", k), 32'(bus.rsp_valid), 32'h0);
      check($sformatf("stale_idle%0d", k), 32'(bus.busy), 32'h0);
    end

    // Foreign-ID pulse during WAIT is ignored; the real response follows
    stall     = 1'b0;
    res_delay = 2;
    accept_req("idmis", 4'b0010, 1, c0);
    @(posedge clk);
    #1;
    inj_valid = 1'b1;
    inj_id    = 4'd0;
    inj_data  = 16'hDEAD;
    @(posedge clk);
    #1;
    inj_valid = 1'b0;
    expect_rsp("idmis", 1, 1'b0, 5, c0);

    // Reset during WAIT aborts with no response
    accept_req("rst", 4'b0100, 2, c0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset("rst_wait");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_rsp%0d", k), 32'(bus.rsp_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // res_out_ready low holds off the grant; rr_ptr restarted from 0
    bus.res_out_ready = 1'b0;
    bus.req_valid     = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("notready_req_ready%0d", k), 32'(bus.req_ready), 32'h0);
      check($sformatf("notready_busy%0d", k), 32'(bus.busy), 32'h0);
    end
    bus.res_out_ready = 1'b1;
    accept_req("post_rst", 4'b1000, 3, c0);
    expect_rsp("post_rst", 3, 1'b0, 5, c0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/resource_arbiter.md
# resource_arbiter

- Shares one `shared_resource` instance among `NUM_REQ` requesters.
- Arbitration is round-robin, with one transaction in flight at a time.
- The arbiter tags each issued request with the requester index and steers the matching response back to that requester, restoring the requester's own ID.
- A watchdog returns an error response if the resource does not answer within `TIMEOUT` cycles.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..2^`ID_WIDTH`)
- `TIMEOUT`, 64, maximum WAIT cycles before an error response
- `TIMEOUT_WIDTH`, 7, counter width; must hold `TIMEOUT`

Ports (widths use `defines.vh` macros):
- `clk` in 1: single clock; all state changes on the rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `req_valid` in `NUM_REQ`: request pending, one bit per requester
- `req_address` in `NUM_REQ*ADDRESS_WIDTH`: flattened; slice i belongs to requester i
- `req_id` in `NUM_REQ*ID_WIDTH`: flattened requester tags
- `req_ready` out `NUM_REQ`: one-hot accept; a transfer occurs when `req_valid[i] & req_ready[i]`
- `rsp_valid` out `NUM_REQ`: one-hot, one-cycle response pulse
- `rsp_data` out `DATA_WIDTH`: response data
- `rsp_id` out `ID_WIDTH`: original requester tag
- `rsp_error` out 1: set when the response is due to a timeout
- `res_in_address` out `ADDRESS_WIDTH`: to resource
- `res_in_id` out `ID_WIDTH`: to resource
- `res_in_valid` out 1: to resource
- `res_out_data` in `DATA_WIDTH`: from resource
- `res_out_id` in `ID_WIDTH`: from resource
- `res_out_valid` in 1: from resource
- `res_out_ready` in 1: from resource
- `busy` out 1: high whenever the state is not IDLE
- `grant_idx` out clog2(`NUM_REQ`): index of the current or last granted requester

## Operation
FSM states are IDLE, ISSUE, WAIT and RESPOND.

- **IDLE**
  - `req_ready` is combinational: `req_ready[i] = (state==IDLE) & res_out_ready & winner[i]`.
  - `winner` is the first set `req_valid` bit scanning upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - On a transfer: latch the address, `req_id` and index g; set `rr_ptr <= (g+1) mod NUM_REQ`; go to ISSUE.
  - If no request is valid or `res_out_ready=0`: stay in IDLE and leave `rr_ptr` unchanged.
- **ISSUE**
  - Assert `res_in_valid=1` for exactly one cycle.
  - Drive `res_in_address` = latched address and `res_in_id` = g, zero-extended.
  - Go to WAIT and clear the watchdog.
- **WAIT**
  - `res_in_valid=0`; the watchdog increments each cycle.
  - If `res_out_valid & res_out_id==g`: latch `res_out_data`, clear the error flag, go to RESPOND.
  - If `res_out_valid` arrives with a different ID: ignore it and keep waiting.
  - If the watchdog reaches `TIMEOUT-1` with no match: latch data 0, set the error flag, go to RESPOND.
  - A match and a timeout in the same cycle resolve as the match.
- **RESPOND**
  - Drive `rsp_valid[g]=1`, `rsp_data`, `rsp_id` = latched tag and `rsp_error`, for one cycle.
  - Go to IDLE.
- `res_out_valid` in IDLE, ISSUE or RESPOND (for example a stale post-timeout response) is discarded.
- Requesters must hold `req_valid`, address and ID stable until accepted. The arbiter never drops an accepted request.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `grant_idx=0`, watchdog 0, `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `rsp_error=0`, `res_in_valid=0`, `res_in_address=0`, `res_in_id=0`, `busy=0`.
- All outputs except `req_ready` are registered.
- Reset asserted mid-transaction aborts the transaction with no response. The resource is reset by the same `reset_n`.
- Latency with resource delay D = `RESOURCE_DELAY`:
  - Accept in cycle 0, `res_in_valid` in cycle 1.
  - Resource response in cycle D+2, `rsp_valid` in cycle D+3.
  - Earliest next accept in cycle D+4.
- Sustained throughput is one transaction per D+4 cycles.
- Timeout response: `rsp_valid` with `rsp_error=1` appears `TIMEOUT`+2 cycles after accept.

## Test plan
- **Single request.** After reset, requester 2 sends address 0x05, tag 3 → `req_ready=4'b0100` in cycle 0; `res_in_valid` with ID 2 in cycle 1; `rsp_valid=4'b0100`, `rsp_data=0x205`, `rsp_id=3`, `rsp_error=0` in cycle D+3.
- **Round robin.** All four requesters hold `req_valid` → grant order 0,1,2,3,0. Each grant is spaced D+4 cycles apart, and each response carries that requester's address + 0x200.
- **Pointer skip.** With `rr_ptr=1` after granting 0, only requesters 0 and 3 valid → requester 3 is granted before 0.
- **Timeout.** With `TIMEOUT` overridden to 4 and the resource model stalled (never `res_out_valid`) → `rsp_error=1`, `rsp_data=0` at accept+6. A late stale `res_out_valid` arriving in IDLE produces no `rsp_valid`.
- **ID mismatch.** In WAIT, a `res_out_valid` pulse carrying another index is ignored. The correct-ID response that follows is delivered.
- **Reset mid-WAIT.** Assert `reset_n=0` during WAIT → all outputs reach their reset values immediately with no `rsp_valid`. After release, a new request completes normally.
